// File: rtl/csr_regfile_if.sv
// ============================================================================
// Module   : csr_regfile_if
// Brief    : Writeback-to-CSR bus: read port, write port, exception/ertn
//            commit, interrupt lines and front-end redirect outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface csr_regfile_if;
  logic [13:0] csr_rnum;
  logic [31:0] csr_rval;
  logic        csr_we;
  logic [13:0] csr_wnum;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wval;
  logic        wb_exc;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] ex_entry;
  logic [31:0] ertn_pc;
  logic        has_int;

  modport master (
    output csr_rnum, csr_we, csr_wnum, csr_wmask, csr_wval,
    output wb_exc, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
    output hw_int_in, ipi_int_in,
    input  csr_rval, ex_entry, ertn_pc, has_int
  );

  modport slave (
    input  csr_rnum, csr_we, csr_wnum, csr_wmask, csr_wval,
    input  wb_exc, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
    input  hw_int_in, ipi_int_in,
    output csr_rval, ex_entry, ertn_pc, has_int
  );
endinterface

`default_nettype wire

// File: rtl/csr_regfile.sv
// ============================================================================
// Module   : csr_regfile
// Brief    : LoongArch control/status register file with constant timer,
//            exception entry/return and interrupt-pending generation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module csr_regfile #(
  parameter logic [31:0] COREID = 32'h0
) (
  input  wire logic       clk,
  input  wire logic       resetn,
  csr_regfile_if.slave    bus
);

  localparam logic [13:0] c_num_crmd   = 14'h000;
  localparam logic [13:0] c_num_prmd   = 14'h001;
  localparam logic [13:0] c_num_ecfg   = 14'h004;
  localparam logic [13:0] c_num_estat  = 14'h005;
  localparam logic [13:0] c_num_era    = 14'h006;
  localparam logic [13:0] c_num_badv   = 14'h007;
  localparam logic [13:0] c_num_eentry = 14'h00C;
  localparam logic [13:0] c_num_save0  = 14'h030;
  localparam logic [13:0] c_num_save1  = 14'h031;
  localparam logic [13:0] c_num_save2  = 14'h032;
  localparam logic [13:0] c_num_save3  = 14'h033;
  localparam logic [13:0] c_num_tid    = 14'h040;
  localparam logic [13:0] c_num_tcfg   = 14'h041;
  localparam logic [13:0] c_num_tval   = 14'h042;
  localparam logic [13:0] c_num_ticlr  = 14'h044;

  localparam logic [31:0] c_mask_crmd   = 32'h0000_01FF;
  localparam logic [31:0] c_mask_prmd   = 32'h0000_0007;
  localparam logic [31:0] c_mask_ecfg   = 32'h0000_1BFF;
  localparam logic [31:0] c_mask_eentry = 32'hFFFF_FFC0;

  localparam logic [5:0] c_ecode_ade = 6'h08;
  localparam logic [5:0] c_ecode_ale = 6'h09;

  function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                          input logic [31:0] wval,
                                          input logic [31:0] wmask);
    return (wval & wmask) | (old_val & ~wmask);
  endfunction

  logic [31:0] r_crmd;
  logic [31:0] r_prmd;
  logic [31:0] r_ecfg;
  logic [1:0]  r_is_sw;
  logic [7:0]  r_is_hw;
  logic        r_is_timer;
  logic        r_is_ipi;
  logic [5:0]  r_ecode;
  logic [8:0]  r_esubcode;
  logic [31:0] r_era;
  logic [31:0] r_badv;
  logic [31:0] r_eentry;
  logic [31:0] r_save0;
  logic [31:0] r_save1;
  logic [31:0] r_save2;
  logic [31:0] r_save3;
  logic [31:0] r_tid;
  logic [31:1] r_tcfg_hi;
  logic        r_tcfg_en;
  logic [31:0] r_tval;
  logic        r_timer_en;

  logic        w_we;
  logic        w_wr_crmd, w_wr_prmd, w_wr_ecfg, w_wr_estat, w_wr_era, w_wr_badv;
  logic        w_wr_eentry, w_wr_save0, w_wr_save1, w_wr_save2, w_wr_save3;
  logic        w_wr_tid, w_wr_tcfg, w_wr_ticlr;
  logic [31:0] w_estat;
  logic [31:0] w_tcfg;
  logic [31:0] w_tcfg_new;
  logic [1:0]  w_is_sw_new;
  logic        w_timer_fire;
  logic        w_ticlr;
  logic [31:0] w_rval;

  // Exception and ertn both pre-empt any CSR write issued in the same cycle.
  assign w_we        = bus.csr_we & ~bus.wb_exc & ~bus.ertn_flush;
  assign w_wr_crmd   = w_we & (bus.csr_wnum == c_num_crmd);
  assign w_wr_prmd   = w_we & (bus.csr_wnum == c_num_prmd);
  assign w_wr_ecfg   = w_we & (bus.csr_wnum == c_num_ecfg);
  assign w_wr_estat  = w_we & (bus.csr_wnum == c_num_estat);
  assign w_wr_era    = w_we & (bus.csr_wnum == c_num_era);
  assign w_wr_badv   = w_we & (bus.csr_wnum == c_num_badv);
  assign w_wr_eentry = w_we & (bus.csr_wnum == c_num_eentry);
  assign w_wr_save0  = w_we & (bus.csr_wnum == c_num_save0);
  assign w_wr_save1  = w_we & (bus.csr_wnum == c_num_save1);
  assign w_wr_save2  = w_we & (bus.csr_wnum == c_num_save2);
  assign w_wr_save3  = w_we & (bus.csr_wnum == c_num_save3);
  assign w_wr_tid    = w_we & (bus.csr_wnum == c_num_tid);
  assign w_wr_tcfg   = w_we & (bus.csr_wnum == c_num_tcfg);
  assign w_wr_ticlr  = w_we & (bus.csr_wnum == c_num_ticlr);

  assign w_estat = {1'b0, r_esubcode, r_ecode, 3'b000, r_is_ipi, r_is_timer,
                    1'b0, r_is_hw, r_is_sw};
  assign w_tcfg      = {r_tcfg_hi, r_tcfg_en};
  assign w_tcfg_new  = f_merge(w_tcfg, bus.csr_wval, bus.csr_wmask);
  assign w_is_sw_new = (bus.csr_wval[1:0] & bus.csr_wmask[1:0]) |
                       (r_is_sw & ~bus.csr_wmask[1:0]);

  // TICLR reads as zero, so its merged bit0 is just the masked write data.
  assign w_ticlr      = w_wr_ticlr & bus.csr_wval[0] & bus.csr_wmask[0];
  assign w_timer_fire = r_timer_en & (r_tval == 32'h0) & ~w_wr_tcfg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_crmd     <= 32'h0000_0008;
      r_prmd     <= 32'h0;
      r_ecfg     <= 32'h0;
      r_is_sw    <= 2'b00;
      r_is_timer <= 1'b0;
      r_timer_en <= 1'b0;
      r_tcfg_en  <= 1'b0;
      r_tid      <= COREID;
    end else begin
      if (bus.wb_exc) begin
        r_crmd <= r_crmd & ~32'h0000_0007;
        r_prmd <= {29'h0, r_crmd[2:0]};
      end else if (bus.ertn_flush) begin
        r_crmd <= {r_crmd[31:3], r_prmd[2:0]};
      end else begin
        if (w_wr_crmd)
          r_crmd <= f_merge(r_crmd, bus.csr_wval, bus.csr_wmask) & c_mask_crmd;
        if (w_wr_prmd)
          r_prmd <= f_merge(r_prmd, bus.csr_wval, bus.csr_wmask) & c_mask_prmd;
      end
      if (w_wr_ecfg)
        r_ecfg <= f_merge(r_ecfg, bus.csr_wval, bus.csr_wmask) & c_mask_ecfg;
      if (w_wr_estat)
        r_is_sw <= w_is_sw_new;
      if (w_wr_tid)
        r_tid <= f_merge(r_tid, bus.csr_wval, bus.csr_wmask);
      if (w_wr_tcfg) begin
        r_tcfg_en  <= w_tcfg_new[0];
        r_timer_en <= w_tcfg_new[0];
      end else if (w_timer_fire && !w_tcfg[1]) begin
        r_timer_en <= 1'b0;
      end
      // Expiry outranks a simultaneous TICLR so no timer event is lost.
      if (w_timer_fire)
        r_is_timer <= 1'b1;
      else if (w_ticlr)
        r_is_timer <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    r_is_hw  <= bus.hw_int_in;
    r_is_ipi <= bus.ipi_int_in;
    if (bus.wb_exc) begin
      r_era      <= bus.wb_pc;
      r_ecode    <= bus.wb_ecode;
      r_esubcode <= bus.wb_esubcode;
      if (bus.wb_ecode == c_ecode_ade)
        r_badv <= bus.wb_pc;
      else if (bus.wb_ecode == c_ecode_ale)
        r_badv <= bus.wb_vaddr;
    end
    if (w_wr_era)    r_era    <= f_merge(r_era, bus.csr_wval, bus.csr_wmask);
    if (w_wr_badv)   r_badv   <= f_merge(r_badv, bus.csr_wval, bus.csr_wmask);
    if (w_wr_eentry)
      r_eentry <= f_merge(r_eentry, bus.csr_wval, bus.csr_wmask) & c_mask_eentry;
    if (w_wr_save0)  r_save0  <= f_merge(r_save0, bus.csr_wval, bus.csr_wmask);
    if (w_wr_save1)  r_save1  <= f_merge(r_save1, bus.csr_wval, bus.csr_wmask);
    if (w_wr_save2)  r_save2  <= f_merge(r_save2, bus.csr_wval, bus.csr_wmask);
    if (w_wr_save3)  r_save3  <= f_merge(r_save3, bus.csr_wval, bus.csr_wmask);
    if (w_wr_tcfg) begin
      r_tcfg_hi <= w_tcfg_new[31:1];
      r_tval    <= {w_tcfg_new[31:2], 2'b00};
    end else if (r_timer_en) begin
      if (r_tval != 32'h0)
        r_tval <= r_tval - 32'h1;
      else if (w_tcfg[1])
        r_tval <= {w_tcfg[31:2], 2'b00};
    end
  end

  always_comb begin
    w_rval = 32'h0;
    case (bus.csr_rnum)
      c_num_crmd:   w_rval = r_crmd;
      c_num_prmd:   w_rval = r_prmd;
      c_num_ecfg:   w_rval = r_ecfg;
      c_num_estat:  w_rval = w_estat;
      c_num_era:    w_rval = r_era;
      c_num_badv:   w_rval = r_badv;
      c_num_eentry: w_rval = r_eentry;
      c_num_save0:  w_rval = r_save0;
      c_num_save1:  w_rval = r_save1;
      c_num_save2:  w_rval = r_save2;
      c_num_save3:  w_rval = r_save3;
      c_num_tid:    w_rval = r_tid;
      c_num_tcfg:   w_rval = w_tcfg;
      c_num_tval:   w_rval = r_tval;
      default:      w_rval = 32'h0;
    endcase
  end

  assign bus.csr_rval = w_rval;
  assign bus.ex_entry = r_eentry;
  assign bus.ertn_pc  = r_era;
  assign bus.has_int  = (|(w_estat[12:0] & r_ecfg[12:0])) & r_crmd[2];

endmodule

`default_nettype wire

// File: tb/tb_csr_regfile.sv
// ============================================================================
// Module   : tb_csr_regfile
// Brief    : Directed scoreboard bench for csr_regfile.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_csr_regfile;

  localparam logic [31:0] c_coreid = 32'h0000_0005;
  localparam logic [13:0] c_crmd = 14'h000, c_prmd = 14'h001, c_ecfg = 14'h004;
  localparam logic [13:0] c_estat = 14'h005, c_era = 14'h006, c_badv = 14'h007;
  localparam logic [13:0] c_eentry = 14'h00C, c_save0 = 14'h030, c_tid = 14'h040;
  localparam logic [13:0] c_tcfg = 14'h041, c_tval = 14'h042, c_ticlr = 14'h044;

  logic clk = 1'b0;
  logic resetn;
  always #10 clk = ~clk;

  csr_regfile_if bus();

  csr_regfile #(.COREID(c_coreid)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic compare(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic rd(input logic [13:0] n, input logic [31:0] e, input string tag);
    expect_val(tag, e);
    bus.csr_rnum = n;
    #1;
    compare(bus.csr_rval);
  endtask

  task automatic rd_mask(input logic [13:0] n, input logic [31:0] m,
                         input logic [31:0] e, input string tag);
    expect_val(tag, e);
    bus.csr_rnum = n;
    #1;
    compare(bus.csr_rval & m);
  endtask

  task automatic chk_int(input logic e, input string tag);
    expect_val(tag, {31'h0, e});
    #1;
    compare({31'h0, bus.has_int});
  endtask

  task automatic wr(input logic [13:0] n, input logic [31:0] v, input logic [31:0] m);
    bus.csr_we    = 1'b1;
    bus.csr_wnum  = n;
    bus.csr_wval  = v;
    bus.csr_wmask = m;
    step();
    bus.csr_we    = 1'b0;
  endtask

  initial begin
    resetn          = 1'b0;
    bus.csr_rnum    = '0;
    bus.csr_we      = 1'b0;
    bus.csr_wnum    = '0;
    bus.csr_wmask   = '0;
    bus.csr_wval    = '0;
    bus.wb_exc      = 1'b0;
    bus.wb_ecode    = '0;
    bus.wb_esubcode = '0;
    bus.wb_pc       = '0;
    bus.wb_vaddr    = '0;
    bus.ertn_flush  = 1'b0;
    bus.hw_int_in   = '0;
    bus.ipi_int_in  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    step();

    rd(c_crmd, 32'h8, "rst_crmd");
    rd(c_prmd, 32'h0, "rst_prmd");
    rd(c_ecfg, 32'h0, "rst_ecfg");
    rd(c_tid, c_coreid, "rst_tid");
    chk_int(1'b0, "rst_has_int");

    // Raise a real interrupt, then pull reset mid-cycle.
    wr(c_ecfg, 32'h4, 32'hFFFF_FFFF);
    wr(c_crmd, 32'h4, 32'h4);
    wr(c_tid, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    bus.hw_int_in = 8'h01;
    step();
    chk_int(1'b1, "hw_int_pending");
    rd(c_crmd, 32'hC, "crmd_ie_set");
    resetn = 1'b0;
    #1;
    rd(c_crmd, 32'h8, "async_rst_crmd");
    rd(c_ecfg, 32'h0, "async_rst_ecfg");
    rd(c_tid, c_coreid, "async_rst_tid");
    chk_int(1'b0, "async_rst_has_int");
    step();
    bus.hw_int_in = 8'h00;
    resetn = 1'b1;
    step();

    // Masked write, visible only from the next cycle.
    bus.csr_we    = 1'b1;
    bus.csr_wnum  = c_crmd;
    bus.csr_wval  = 32'hFFFF_FFFF;
    bus.csr_wmask = 32'h4;
    rd(c_crmd, 32'h8, "crmd_no_bypass");
    step();
    bus.csr_we = 1'b0;
    rd(c_crmd, 32'hC, "crmd_masked");

    wr(c_ecfg, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(c_ecfg, 32'h1BFF, "ecfg_field");
    wr(c_ecfg, 32'h0, 32'hFFFF_FFFF);
    wr(c_eentry, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(c_eentry, 32'hFFFF_FFC0, "eentry_field");
    wr(c_prmd, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(c_prmd, 32'h7, "prmd_field");
    wr(c_prmd, 32'h0, 32'hFFFF_FFFF);
    wr(14'h002, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd(14'h002, 32'h0, "unimpl_read");
    rd(c_ticlr, 32'h0, "ticlr_read");

    // Exception with a colliding SAVE0 write, then ertn.
    wr(c_crmd, 32'h7, 32'h7);
    rd(c_crmd, 32'hF, "crmd_pre_exc");
    wr(c_save0, 32'h55, 32'hFFFF_FFFF);
    bus.wb_exc      = 1'b1;
    bus.wb_ecode    = 6'h09;
    bus.wb_esubcode = 9'h0;
    bus.wb_pc       = 32'h1C00_0100;
    bus.wb_vaddr    = 32'h1234_5671;
    bus.csr_we      = 1'b1;
    bus.csr_wnum    = c_save0;
    bus.csr_wval    = 32'hAA;
    bus.csr_wmask   = 32'hFFFF_FFFF;
    step();
    bus.wb_exc = 1'b0;
    bus.csr_we = 1'b0;
    rd(c_prmd, 32'h7, "exc_prmd");
    rd(c_crmd, 32'h8, "exc_crmd");
    rd(c_era, 32'h1C00_0100, "exc_era");
    rd(c_badv, 32'h1234_5671, "exc_badv");
    rd_mask(c_estat, 32'h003F_0000, 32'h0009_0000, "exc_ecode");
    rd(c_save0, 32'h55, "exc_save0_kept");
    expect_val("ex_entry", 32'hFFFF_FFC0);
    compare(bus.ex_entry);
    expect_val("ertn_pc", 32'h1C00_0100);
    compare(bus.ertn_pc);
    bus.ertn_flush = 1'b1;
    step();
    bus.ertn_flush = 1'b0;
    rd(c_crmd, 32'hF, "ertn_crmd");

    // One-shot timer.
    wr(c_ecfg, 32'h800, 32'hFFFF_FFFF);
    wr(c_tcfg, 32'h9, 32'hFFFF_FFFF);
    for (int k = 8; k >= 0; k--) begin
      rd(c_tval, k, "oneshot_tval");
      rd_mask(c_estat, 32'h800, 32'h0, "oneshot_is11_low");
      step();
    end
    rd_mask(c_estat, 32'h800, 32'h800, "oneshot_fire");
    rd(c_tval, 32'h0, "oneshot_tval_zero");
    chk_int(1'b1, "oneshot_has_int");
    rd(c_tcfg, 32'h9, "tcfg_readback");
    step();
    rd(c_tval, 32'h0, "oneshot_tval_hold");
    rd_mask(c_estat, 32'h800, 32'h800, "oneshot_is11_hold");
    wr(c_ticlr, 32'h1, 32'h1);
    rd_mask(c_estat, 32'h800, 32'h0, "ticlr_clear");
    chk_int(1'b0, "ticlr_has_int");

    // Periodic timer, then a TICLR colliding with expiry.
    wr(c_tcfg, 32'hB, 32'hFFFF_FFFF);
    for (int k = 8; k >= 0; k--) begin
      rd(c_tval, k, "periodic_tval");
      step();
    end
    rd(c_tval, 32'h8, "periodic_reload");
    rd_mask(c_estat, 32'h800, 32'h800, "periodic_fire");
    wr(c_ticlr, 32'h1, 32'h1);
    rd_mask(c_estat, 32'h800, 32'h0, "periodic_clear");
    for (int k = 7; k >= 1; k--) begin
      rd(c_tval, k, "periodic2_tval");
      step();
    end
    rd(c_tval, 32'h0, "periodic2_zero");
    rd_mask(c_estat, 32'h800, 32'h0, "periodic2_pre_fire");
    bus.csr_we    = 1'b1;
    bus.csr_wnum  = c_ticlr;
    bus.csr_wval  = 32'h1;
    bus.csr_wmask = 32'h1;
    step();
    bus.csr_we = 1'b0;
    rd_mask(c_estat, 32'h800, 32'h800, "fire_beats_ticlr");
    rd(c_tval, 32'h8, "periodic2_reload");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
